// File: rtl/key_sched_seq_pkg.sv
// Shared definitions for the AES-128 key-schedule sequencer.
// Holds the key and round-count constants, the round-index type, the FSM
// state encodings, the round-constant table and the GF(2^8) helpers that
// the expansion core uses to build its S-box.
package key_sched_seq_pkg;

    localparam int AES_NR   = 10;
    localparam int AES_KEYW = 128;
    localparam int AES_IDXW = 4;

    typedef logic [AES_IDXW-1:0] idx_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Round constant for expansion iteration 1..10; anything else yields 0.
    function automatic logic [7:0] rcon(input logic [7:0] iter);
        case (iter)
            8'd1:    rcon = 8'h01;
            8'd2:    rcon = 8'h02;
            8'd3:    rcon = 8'h04;
            8'd4:    rcon = 8'h08;
            8'd5:    rcon = 8'h10;
            8'd6:    rcon = 8'h20;
            8'd7:    rcon = 8'h40;
            8'd8:    rcon = 8'h80;
            8'd9:    rcon = 8'h1b;
            8'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // S-box = affine transform of the field inverse.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = gf_inv(a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_sched_seq_if.sv
// Handshake/bus bundle between the key-schedule sequencer and its user.
// key_in/vin: start request; rk_out/rk_idx/vout/rk_ready: round-key stream;
// busy/done/tbl_valid: status; rd_idx/rd_key: random-access table port.
// master = the consumer/driver side, slave = the sequencer.
interface key_sched_seq_if #(parameter int IDXW = 4) ();

    logic [127:0]    key_in;
    logic            vin;
    logic            busy;
    logic [127:0]    rk_out;
    logic [IDXW-1:0] rk_idx;
    logic            vout;
    logic            rk_ready;
    logic            done;
    logic            tbl_valid;
    logic [IDXW-1:0] rd_idx;
    logic [127:0]    rd_key;

    modport master (
        output key_in, vin, rk_ready, rd_idx,
        input  busy, rk_out, rk_idx, vout, done, tbl_valid, rd_key
    );

    modport slave (
        input  key_in, vin, rk_ready, rd_idx,
        output busy, rk_out, rk_idx, vout, done, tbl_valid, rd_key
    );

endinterface

// File: rtl/key_sched_seq_ke_core.sv
// Combinational AES-128 key-expansion step.
// key_in: current round key (w0 in bits 127:96); iter: expansion iteration
// number 1..10 (selects rcon); key_out: next round key.
module ke_core
    import key_sched_seq_pkg::*;
(
    input  logic [AES_KEYW-1:0] key_in,
    input  logic [7:0]          iter,
    output logic [AES_KEYW-1:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, tmp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    // RotWord then SubWord on the last word, then fold in the round constant.
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign tmp = sub ^ {rcon(iter), 24'h000000};

    assign n0 = w0 ^ tmp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/key_sched_seq.sv
// Iterative AES-128 key-schedule sequencer.
// Ports: clk, rst (synchronous, active high), bus (slave modport):
//   key_in/vin start a run from IDLE; rk_out/rk_idx/vout stream round keys
//   0..NR, each held until rk_ready; done pulses for one cycle after the last
//   key is accepted; tbl_valid marks a complete stored schedule; rd_idx/rd_key
//   read the stored round keys combinationally (0 beyond NR).
module key_sched_seq
    import key_sched_seq_pkg::*;
#(
    parameter int NR   = AES_NR,
    parameter int IDXW = AES_IDXW
)
(
    input  logic           clk,
    input  logic           rst,
    key_sched_seq_if.slave bus
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR);

    logic [1:0]          state;
    logic [AES_KEYW-1:0] cur_key;
    logic [AES_KEYW-1:0] next_key;
    logic [IDXW-1:0]     idx;
    logic                tbl_valid_q;
    logic [7:0]          iter;
    logic                start;
    logic                step;
    logic [AES_KEYW-1:0] tbl [0:NR];

    assign start = (state == ST_IDLE) && bus.vin;
    // An accepted key below the last one advances the expansion.
    assign step  = (state == ST_EMIT) && bus.rk_ready && (idx != LAST_IDX);
    assign iter  = 8'(idx) + 8'd1;

    ke_core u_ke_core (
        .key_in  (cur_key),
        .iter    (iter),
        .key_out (next_key)
    );

    // Control FSM and the current-key register; the core output is only
    // ever consumed through this register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_key     <= '0;
            idx         <= '0;
            tbl_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.vin) begin
                        cur_key     <= bus.key_in;
                        idx         <= '0;
                        tbl_valid_q <= 1'b0;
                        state       <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.rk_ready) begin
                        if (idx != LAST_IDX) begin
                            cur_key <= next_key;
                            idx     <= idx + 1'b1;
                        end else begin
                            tbl_valid_q <= 1'b1;
                            state       <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Round-key table; contents only matter once tbl_valid is set, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (start) begin
                tbl[0] <= bus.key_in;
            end else if (step) begin
                tbl[idx + 1'b1] <= next_key;
            end
        end
    end

    assign bus.rd_key    = (bus.rd_idx <= LAST_IDX) ? tbl[bus.rd_idx] : '0;
    assign bus.busy      = (state == ST_EMIT);
    assign bus.vout      = (state == ST_EMIT);
    assign bus.done      = (state == ST_FIN);
    assign bus.tbl_valid = tbl_valid_q;
    assign bus.rk_out    = cur_key;
    assign bus.rk_idx    = idx;

endmodule

// File: tb/tb_key_sched_seq.sv
// Testbench for key_sched_seq: scoreboard of expected round keys, filled when
// a start is driven and drained by a monitor as keys are accepted.
module tb_key_sched_seq;
    import key_sched_seq_pkg::*;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           known;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_sched_seq_if #(.IDXW(AES_IDXW)) bus();

    key_sched_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [127:0] fipsKeys [0:10];
    logic [127:0] key2Keys [0:10];
    bit           key2Known [0:10];
    exp_t         sbQ [$];

    int testsRun     = 0;
    int failCount    = 0;
    int cyc          = 0;
    int startCyc     = 0;
    int lastFinalCyc = -100;
    int doneCount    = 0;
    int readyMode    = 0;
    bit latencyCheck = 1'b0;
    bit autoRestart  = 1'b0;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_TWO  = 128'h000102030405060708090a0b0c0d0e0f;

    always @(posedge clk) cyc++;

    // Consumer ready: always 1, or pseudo-random in backpressure mode.
    always @(posedge clk) begin
        #1;
        bus.rk_ready = (readyMode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic pushSchedule(input int sched);
        for (int i = 0; i <= 10; i++) begin
            exp_t e;
            e.idx = 4'(i);
            if (sched == 0) begin
                e.key   = fipsKeys[i];
                e.known = 1'b1;
            end else begin
                e.key   = key2Keys[i];
                e.known = key2Known[i];
            end
            sbQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] key, input int sched);
        @(posedge clk); #1;
        bus.key_in = key;
        bus.vin    = 1'b1;
        startCyc   = cyc;
        pushSchedule(sched);
        @(posedge clk); #1;
        bus.vin = 1'b0;
    endtask

    task automatic waitRuns(input int n, input int budget);
        int k;
        k = 0;
        while (doneCount < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        checkOutput("run_finished", 128'(doneCount >= n), 128'(1'b1));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_count", 128'(doneCount), 128'(n));
        checkOutput("scoreboard_empty", 128'(sbQ.size()), 128'(0));
        doneCount = 0;
    endtask

    task automatic waitForIdx(input logic [3:0] target, input int budget);
        int k;
        k = 0;
        while (!(bus.vout && bus.rk_idx == target) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("reached_idx", 128'(bus.rk_idx), 128'(target));
    endtask

    // Monitor: compare the held key with the scoreboard head every valid
    // cycle (covers stall stability), pop on accept, police done timing.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.vout) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_vout", 128'(bus.vout), 128'(1'b0));
                end else begin
                    checkOutput("rk_idx", 128'(bus.rk_idx), 128'(sbQ[0].idx));
                    if (sbQ[0].known)
                        checkOutput($sformatf("rk_out[%0d]", sbQ[0].idx), bus.rk_out, sbQ[0].key);
                    if (bus.rk_ready) begin
                        if (latencyCheck)
                            checkOutput("latency", 128'(cyc - startCyc), 128'(int'(sbQ[0].idx) + 1));
                        if (sbQ[0].idx == 4'd10) lastFinalCyc = cyc;
                        void'(sbQ.pop_front());
                    end
                end
            end
            if (bus.done) begin
                doneCount++;
                checkOutput("done_timing", 128'(cyc - lastFinalCyc), 128'(1));
                if (autoRestart) begin
                    autoRestart = 1'b0;
                    startCyc    = cyc + 1;
                    pushSchedule(1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        fipsKeys[0]  = KEY_FIPS;
        fipsKeys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fipsKeys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fipsKeys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fipsKeys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fipsKeys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fipsKeys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fipsKeys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fipsKeys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fipsKeys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fipsKeys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) begin
            key2Keys[i]  = '0;
            key2Known[i] = 1'b0;
        end
        key2Keys[0]  = KEY_TWO;
        key2Keys[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        key2Keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        key2Known[0]  = 1'b1;
        key2Known[1]  = 1'b1;
        key2Known[10] = 1'b1;

        bus.vin    = 1'b0;
        bus.key_in = '0;
        bus.rd_idx = '0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 128'(bus.busy), 128'(1'b0));
        checkOutput("reset_vout", 128'(bus.vout), 128'(1'b0));
        checkOutput("reset_done", 128'(bus.done), 128'(1'b0));
        checkOutput("reset_tbl_valid", 128'(bus.tbl_valid), 128'(1'b0));
        checkOutput("reset_rk_idx", 128'(bus.rk_idx), 128'(0));
        checkOutput("reset_rk_out", bus.rk_out, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Full-speed FIPS-197 run.
        $display("[TB] full-speed FIPS-197 schedule");
        readyMode    = 0;
        latencyCheck = 1'b1;
        applyStimulus(KEY_FIPS, 0);
        checkOutput("busy_after_start", 128'(bus.busy), 128'(1'b1));
        waitRuns(1, 40);

        // Table sweep.
        $display("[TB] table read sweep");
        checkOutput("tbl_valid_after_done", 128'(bus.tbl_valid), 128'(1'b1));
        for (int i = 0; i <= 10; i++) begin
            bus.rd_idx = 4'(i);
            #1;
            checkOutput($sformatf("rd_key[%0d]", i), bus.rd_key, fipsKeys[i]);
        end
        bus.rd_idx = 4'd11;
        #1;
        checkOutput("rd_key[11]", bus.rd_key, 128'(0));
        bus.rd_idx = 4'd15;
        #1;
        checkOutput("rd_key[15]", bus.rd_key, 128'(0));

        // Backpressure with an ignored start at idx 4.
        $display("[TB] backpressure and start while busy");
        readyMode    = 1;
        latencyCheck = 1'b0;
        applyStimulus(KEY_FIPS, 0);
        checkOutput("tbl_valid_cleared", 128'(bus.tbl_valid), 128'(1'b0));
        waitForIdx(4'd4, 200);
        bus.key_in = KEY_TWO;
        bus.vin    = 1'b1;
        @(posedge clk); #1;
        bus.vin = 1'b0;
        waitRuns(1, 400);
        bus.rd_idx = 4'd10;
        #1;
        checkOutput("tbl_after_busy_start", bus.rd_key, fipsKeys[10]);

        // Reset in the middle of a run, then a fresh key.
        $display("[TB] reset mid-run");
        readyMode    = 0;
        latencyCheck = 1'b1;
        applyStimulus(KEY_FIPS, 0);
        waitForIdx(4'd6, 40);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_vout", 128'(bus.vout), 128'(1'b0));
        checkOutput("midreset_busy", 128'(bus.busy), 128'(1'b0));
        checkOutput("midreset_tbl_valid", 128'(bus.tbl_valid), 128'(1'b0));
        checkOutput("midreset_rk_idx", 128'(bus.rk_idx), 128'(0));
        rst = 1'b0;
        sbQ.delete();
        repeat (3) begin
            @(negedge clk);
            checkOutput("midreset_no_done", 128'(bus.done), 128'(1'b0));
        end
        checkOutput("midreset_done_count", 128'(doneCount), 128'(0));
        applyStimulus(KEY_TWO, 1);
        waitRuns(1, 40);
        bus.rd_idx = 4'd10;
        #1;
        checkOutput("tbl_key2_rk10", bus.rd_key, key2Keys[10]);

        // vin held high across two runs.
        $display("[TB] back-to-back starts");
        @(posedge clk); #1;
        bus.key_in  = KEY_FIPS;
        bus.vin     = 1'b1;
        startCyc    = cyc;
        pushSchedule(0);
        autoRestart = 1'b1;
        @(posedge clk); #1;
        bus.key_in = KEY_TWO;
        k = 0;
        while (doneCount < 1 && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        k = 0;
        while (!bus.busy && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        bus.vin = 1'b0;
        waitRuns(2, 60);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
